control_seq: RTL and testbench

- Next-generation control unit for the nic8 datapath. It replaces the purely combinational decode plus clock-gated triggers with a synchronous fetch/execute sequencer.
- Owns the instruction register, a FETCH/EXEC/HALT state machine, memory-wait handling, latched ALU flags and an executed-instruction counter.
- Emits active-high, single-cycle enable strobes for the datapath. Datapath registers are clocked by clk and qualified by these enables; no derived clocks are used.

---
 rtl/control_seq.sv | 167 ++++++++++++++++
 tb/tb_control_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_seq.sv
// control_seq: fetch/execute sequencer for the nic8 datapath.
// Owns the instruction register, latched ALU flags and a retired-instruction
// counter. It drives single-cycle enable strobes that qualify datapath
// registers clocked by clk.
module control_seq #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [DATA_W-1:0] a_value,
  input  logic              alu_carry,
  input  logic              alu_shift,
  input  logic              ready,
  output logic [7:0]        ir,
  output logic [1:0]        state,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              en_a,
  output logic              en_b,
  output logic              en_x,
  output logic              en_q,
  output logic              mem_we,
  output logic [2:0]        sel_src,
  output logic              alu_sub,
  output logic              alu_cin,
  output logic              shift_in,
  output logic              flag_c,
  output logic              flag_s,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {
    StFetch = 2'b00,
    StExec  = 2'b01,
    StHalt  = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         ir_q, ir_d;
  logic               flag_c_q, flag_c_d;
  logic               flag_s_q, flag_s_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic [2:0] dest, src;
  logic       bit7, bit3, is_halt, jump_cond, go;

  assign dest    = ir_q[6:4];
  assign src     = ir_q[2:0];
  assign bit7    = ir_q[7];
  assign bit3    = ir_q[3];
  assign is_halt = (ir_q == 8'h08);
  // A cycle only does work when memory is ready and reset is not pending.
  assign go      = ready & ~reset;

  // Jump condition uses the latched flags, never the live ALU outputs.
  always_comb begin
    unique case ({bit7, bit3})
      2'b00:   jump_cond = 1'b1;
      2'b01:   jump_cond = (a_value == '0);
      2'b10:   jump_cond = flag_c_q;
      default: jump_cond = flag_s_q;
    endcase
  end

  // Strobes and ALU controls decoded from state, ir and ready.
  always_comb begin
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    en_a     = 1'b0;
    en_b     = 1'b0;
    en_x     = 1'b0;
    en_q     = 1'b0;
    mem_we   = 1'b0;
    sel_src  = 3'd0;
    alu_sub  = 1'b0;
    alu_cin  = 1'b0;
    shift_in = 1'b0;
    case (state_q)
      StFetch: pc_inc = go;
      StExec: begin
        sel_src  = src;
        alu_sub  = bit3;
        alu_cin  = bit7;
        shift_in = bit3;
        if (go && !is_halt) begin
          // Immediate source steps the PC past the operand byte.
          pc_inc = (src == 3'd0);
          case (dest)
            3'd1:    pc_load = jump_cond;
            3'd2:    en_a    = 1'b1;
            3'd3:    en_b    = 1'b1;
            3'd4:    en_x    = 1'b1;
            3'd5:    mem_we  = 1'b1;
            3'd6:    en_q    = 1'b1;
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Next-state logic for sequencer, IR, flags and retired counter.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    flag_c_d  = flag_c_q;
    flag_s_d  = flag_s_q;
    retired_d = retired_q;
    case (state_q)
      StFetch: begin
        if (ready) begin
          ir_d    = bus_in[7:0];
          state_d = StExec;
        end
      end
      StExec: begin
        if (ready) begin
          retired_d = retired_q + CNT_W'(1);
          if (is_halt) begin
            state_d = StHalt;
          end else begin
            if (src == 3'd6) flag_c_d = alu_carry;
            if (src == 3'd7) flag_s_d = alu_shift;
            if (dest == 3'd0) begin
              // Chained fetch: the bus word becomes the next instruction.
              ir_d    = bus_in[7:0];
              state_d = StExec;
            end else begin
              state_d = StFetch;
            end
          end
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      ir_q      <= 8'h00;
      flag_c_q  <= 1'b0;
      flag_s_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      flag_c_q  <= flag_c_d;
      flag_s_q  <= flag_s_d;
      retired_q <= retired_d;
    end
  end

  assign ir      = ir_q;
  assign state   = state_q;
  assign flag_c  = flag_c_q;
  assign flag_s  = flag_s_q;
  assign retired = retired_q;
  assign halted  = (state_q == StHalt);

endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq: one task per scenario, inline checks.
module tb_control_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] bus_in, a_value;
  logic       alu_carry, alu_shift, ready;

  logic [7:0]  ir;
  logic [1:0]  state;
  logic        pc_inc, pc_load, en_a, en_b, en_x, en_q, mem_we;
  logic [2:0]  sel_src;
  logic        alu_sub, alu_cin, shift_in, flag_c, flag_s, halted;
  logic [15:0] retired;

  // Second instance with a narrow counter to observe wrap-around.
  logic [7:0] w_ir;
  logic [1:0] w_state;
  logic       w_pc_inc, w_pc_load, w_en_a, w_en_b, w_en_x, w_en_q, w_mem_we;
  logic [2:0] w_sel_src;
  logic       w_alu_sub, w_alu_cin, w_shift_in, w_flag_c, w_flag_s, w_halted;
  logic [1:0] w_retired;

  int checks = 0;
  int failures = 0;

  localparam logic [6:0] SPci = 7'b1000000;
  localparam logic [6:0] SPcl = 7'b0100000;
  localparam logic [6:0] SA   = 7'b0010000;
  localparam logic [6:0] SB   = 7'b0001000;
  localparam logic [6:0] SWe  = 7'b0000001;

  logic [6:0] strobes;
  assign strobes = {pc_inc, pc_load, en_a, en_b, en_x, en_q, mem_we};

  control_seq #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus_in(bus_in), .a_value(a_value),
    .alu_carry(alu_carry), .alu_shift(alu_shift), .ready(ready),
    .ir(ir), .state(state), .pc_inc(pc_inc), .pc_load(pc_load),
    .en_a(en_a), .en_b(en_b), .en_x(en_x), .en_q(en_q), .mem_we(mem_we),
    .sel_src(sel_src), .alu_sub(alu_sub), .alu_cin(alu_cin), .shift_in(shift_in),
    .flag_c(flag_c), .flag_s(flag_s), .halted(halted), .retired(retired)
  );

  control_seq #(.DATA_W(8), .CNT_W(2)) dut_w (
    .clk(clk), .reset(reset), .bus_in(bus_in), .a_value(a_value),
    .alu_carry(alu_carry), .alu_shift(alu_shift), .ready(ready),
    .ir(w_ir), .state(w_state), .pc_inc(w_pc_inc), .pc_load(w_pc_load),
    .en_a(w_en_a), .en_b(w_en_b), .en_x(w_en_x), .en_q(w_en_q), .mem_we(w_mem_we),
    .sel_src(w_sel_src), .alu_sub(w_alu_sub), .alu_cin(w_alu_cin),
    .shift_in(w_shift_in), .flag_c(w_flag_c), .flag_s(w_flag_s),
    .halted(w_halted), .retired(w_retired)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; ready = 1'b1; bus_in = 8'h20; a_value = 8'h00;
    alu_carry = 1'b0; alu_shift = 1'b0;
    cyc(); cyc(); settle();
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL rst_state got=%0h exp=0", state); end
    checks++; if (ir !== 8'h00) begin failures++; $display("FAIL rst_ir got=%0h exp=0", ir); end
    checks++; if (retired !== 16'd0 || flag_c !== 1'b0 || flag_s !== 1'b0) begin
      failures++; $display("FAIL rst_regs got=%0d/%0b/%0b exp=0/0/0", retired, flag_c, flag_s); end
    checks++; if (strobes !== 7'b0) begin failures++; $display("FAIL rst_strobes got=%b exp=0", strobes); end
    reset = 1'b0; settle();
    checks++; if (strobes !== SPci) begin failures++; $display("FAIL rst_fetch got=%b exp=%b", strobes, SPci); end
  endtask

  task automatic test_load_a();
    bus_in = 8'h20;
    cyc(); bus_in = 8'hff; settle();
    checks++; if (ir !== 8'h20 || state !== 2'b01) begin
      failures++; $display("FAIL lda_ir got=%0h/%0h exp=20/1", ir, state); end
    checks++; if (strobes !== (SPci | SA) || sel_src !== 3'd0) begin
      failures++; $display("FAIL lda_exec got=%b/%0d exp=%b/0", strobes, sel_src, SPci | SA); end
    cyc();
    checks++; if (state !== 2'b00 || retired !== 16'd1) begin
      failures++; $display("FAIL lda_done got=%0h/%0d exp=0/1", state, retired); end
  endtask

  task automatic test_alu_jump();
    bus_in = 8'h36; alu_carry = 1'b1;
    cyc(); settle();
    checks++; if (strobes !== SB || sel_src !== 3'd6) begin
      failures++; $display("FAIL alu_exec got=%b/%0d exp=%b/6", strobes, sel_src, SB); end
    checks++; if (flag_c !== 1'b0) begin failures++; $display("FAIL alu_flag_early got=%b exp=0", flag_c); end
    cyc(); alu_carry = 1'b0; bus_in = 8'h90;
    checks++; if (flag_c !== 1'b1 || retired !== 16'd2) begin
      failures++; $display("FAIL alu_flag got=%b/%0d exp=1/2", flag_c, retired); end
    cyc(); settle();
    checks++; if (strobes !== (SPci | SPcl) || alu_cin !== 1'b1) begin
      failures++; $display("FAIL jc_exec got=%b/%b exp=%b/1", strobes, alu_cin, SPci | SPcl); end
    cyc();
    checks++; if (retired !== 16'd3 || flag_c !== 1'b1) begin
      failures++; $display("FAIL jc_done got=%0d/%b exp=3/1", retired, flag_c); end
  endtask

  task automatic test_shift_jump();
    bus_in = 8'h77; alu_shift = 1'b1;
    cyc(); settle();
    checks++; if (strobes !== 7'b0 || sel_src !== 3'd7 || shift_in !== 1'b0) begin
      failures++; $display("FAIL sh_exec got=%b/%0d/%b exp=0/7/0", strobes, sel_src, shift_in); end
    cyc(); alu_shift = 1'b0; bus_in = 8'h98;
    checks++; if (flag_s !== 1'b1 || retired !== 16'd4) begin
      failures++; $display("FAIL sh_flag got=%b/%0d exp=1/4", flag_s, retired); end
    cyc(); settle();
    checks++; if (strobes !== (SPci | SPcl)) begin
      failures++; $display("FAIL js_exec got=%b exp=%b", strobes, SPci | SPcl); end
    cyc();
  endtask

  task automatic test_jump_zero();
    bus_in = 8'h18; a_value = 8'h00;
    cyc(); settle();
    checks++; if (strobes !== (SPci | SPcl) || alu_sub !== 1'b1) begin
      failures++; $display("FAIL jz_taken got=%b/%b exp=%b/1", strobes, alu_sub, SPci | SPcl); end
    cyc(); a_value = 8'h01;
    checks++; if (retired !== 16'd6) begin failures++; $display("FAIL jz_ret1 got=%0d exp=6", retired); end
    cyc(); settle();
    checks++; if (strobes !== SPci) begin failures++; $display("FAIL jz_not got=%b exp=%b", strobes, SPci); end
    cyc();
    checks++; if (retired !== 16'd7) begin failures++; $display("FAIL jz_ret2 got=%0d exp=7", retired); end
  endtask

  task automatic test_stall();
    int we_count = 0;
    ready = 1'b0; bus_in = 8'h50;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++; if (strobes !== 7'b0 || state !== 2'b00 || ir !== 8'h18) begin
        failures++; $display("FAIL stall_fetch%0d got=%b/%0h/%0h exp=0/0/18", i, strobes, state, ir); end
      cyc();
    end
    ready = 1'b1;
    cyc(); ready = 1'b0; bus_in = 8'haa;
    for (int i = 0; i < 2; i++) begin
      settle();
      if (mem_we) we_count++;
      checks++; if (strobes !== 7'b0 || state !== 2'b01 || ir !== 8'h50) begin
        failures++; $display("FAIL stall_exec%0d got=%b/%0h/%0h exp=0/1/50", i, strobes, state, ir); end
      cyc();
    end
    ready = 1'b1; settle();
    if (mem_we) we_count++;
    checks++; if (strobes !== (SPci | SWe)) begin
      failures++; $display("FAIL stall_we got=%b exp=%b", strobes, SPci | SWe); end
    cyc();
    if (mem_we) we_count++;
    checks++; if (we_count != 1 || retired !== 16'd8 || state !== 2'b00) begin
      failures++; $display("FAIL stall_done got=%0d/%0d/%0h exp=1/8/0", we_count, retired, state); end
  endtask

  task automatic test_halt();
    bus_in = 8'h08;
    cyc(); settle();
    checks++; if (strobes !== 7'b0) begin failures++; $display("FAIL halt_exec got=%b exp=0", strobes); end
    cyc();
    checks++; if (state !== 2'b10 || halted !== 1'b1 || retired !== 16'd9) begin
      failures++; $display("FAIL halt_enter got=%0h/%b/%0d exp=2/1/9", state, halted, retired); end
    for (int i = 0; i < 10; i++) begin
      bus_in = 8'(i * 37 + 5); ready = i[0]; settle();
      checks++; if (strobes !== 7'b0 || state !== 2'b10 || retired !== 16'd9) begin
        failures++; $display("FAIL halt_hold%0d got=%b/%0h/%0d exp=0/2/9", i, strobes, state, retired); end
      cyc();
    end
    ready = 1'b1; reset = 1'b1;
    cyc(); reset = 1'b0;
    checks++; if (state !== 2'b00 || retired !== 16'd0 || flag_c !== 1'b0 || flag_s !== 1'b0 ||
                  halted !== 1'b0) begin
      failures++; $display("FAIL halt_reset got=%0h/%0d/%b/%b/%b exp=0/0/0/0/0",
                           state, retired, flag_c, flag_s, halted); end
  endtask

  task automatic test_reset_exec();
    bus_in = 8'h20;
    cyc(); reset = 1'b1; settle();
    checks++; if (en_a !== 1'b0 || strobes !== 7'b0) begin
      failures++; $display("FAIL rexec_strobe got=%b exp=0", strobes); end
    cyc(); reset = 1'b0;
    checks++; if (state !== 2'b00 || ir !== 8'h00 || retired !== 16'd0) begin
      failures++; $display("FAIL rexec_state got=%0h/%0h/%0d exp=0/0/0", state, ir, retired); end
  endtask

  task automatic test_back_to_back();
    bus_in = 8'h00;
    cyc(); bus_in = 8'h20; settle();
    checks++; if (strobes !== SPci || state !== 2'b01) begin
      failures++; $display("FAIL chain_exec got=%b/%0h exp=%b/1", strobes, state, SPci); end
    cyc(); bus_in = 8'h33; settle();
    checks++; if (state !== 2'b01 || ir !== 8'h20 || retired !== 16'd1) begin
      failures++; $display("FAIL chain_ir got=%0h/%0h/%0d exp=1/20/1", state, ir, retired); end
    checks++; if (strobes !== (SPci | SA)) begin
      failures++; $display("FAIL chain_lda got=%b exp=%b", strobes, SPci | SA); end
    cyc();
    checks++; if (state !== 2'b00 || retired !== 16'd2) begin
      failures++; $display("FAIL chain_done got=%0h/%0d exp=0/2", state, retired); end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    cyc(); reset = 1'b0; bus_in = 8'h70;
    for (int i = 0; i < 5; i++) begin
      cyc(); cyc();
    end
    checks++; if (retired !== 16'd5) begin failures++; $display("FAIL wrap_wide got=%0d exp=5", retired); end
    checks++; if (w_retired !== 2'd1) begin failures++; $display("FAIL wrap_narrow got=%0d exp=1", w_retired); end
  endtask

  initial begin
    test_reset();
    test_load_a();
    test_alu_jump();
    test_shift_jump();
    test_jump_zero();
    test_stall();
    test_halt();
    test_reset_exec();
    test_back_to_back();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
